// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage access engine.
package mem_access_unit_pkg;

    localparam int unsigned DATA_W          = 32;
    localparam int unsigned REG_ADDR_W      = 5;
    localparam int unsigned TIMEOUT_CYC_DEF = 255;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDone   = 2'd2
    } state_e;

endpackage

// File: rtl/mem_access_unit.sv
// MEM-stage engine: issues one req/ack memory transaction per load/store,
// stalls the pipeline while it is outstanding and presents MEM/WB fields.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [DATA_W-1:0]     ALUResult_i,
    input  logic [DATA_W-1:0]     RS2data_i,
    input  logic                  MemRead_i,
    input  logic                  MemWrite_i,
    input  logic                  MemtoReg_i,
    input  logic                  RegWrite_i,
    input  logic [REG_ADDR_W-1:0] RDaddr_i,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [DATA_W-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    input  logic                  mem_ack_i,
    input  logic [DATA_W-1:0]     mem_rdata_i,
    output logic                  stall_o,
    output logic [DATA_W-1:0]     ALUResult_o,
    output logic [DATA_W-1:0]     ReadData_o,
    output logic                  MemtoReg_o,
    output logic                  RegWrite_o,
    output logic [REG_ADDR_W-1:0] RDaddr_o,
    output logic                  error_o
);

    localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);

    state_e              r_state, w_state_d;
    logic [CNT_W-1:0]    r_cnt, w_cnt_d;
    logic                r_err, w_err_d;
    logic                r_mis_err, w_mis_err_d;
    logic                r_we, w_we_d;
    logic [DATA_W-1:0]   r_addr, w_addr_d;
    logic [DATA_W-1:0]   r_wdata, w_wdata_d;
    logic [DATA_W-1:0]   r_rdata, w_rdata_d;

    logic w_acc;
    logic w_mis;
    logic w_stall;
    logic w_in_idle;
    logic w_in_access;
    logic w_in_done;

    assign w_acc       = start_i & (MemRead_i | MemWrite_i);
    assign w_mis       = w_acc & (ALUResult_i[1:0] != 2'b00);
    assign w_in_idle   = (r_state == StIdle);
    assign w_in_access = (r_state == StAccess);
    assign w_in_done   = (r_state == StDone);

    // Next-state, counter and datapath register update.
    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = r_cnt;
        w_err_d     = r_err;
        w_mis_err_d = 1'b0;
        w_we_d      = r_we;
        w_addr_d    = r_addr;
        w_wdata_d   = r_wdata;
        w_rdata_d   = r_rdata;

        if (!start_i) begin
            // Pipeline flush: abandon whatever is in flight.
            w_state_d = StIdle;
            w_cnt_d   = '0;
            w_err_d   = 1'b0;
            w_we_d    = 1'b0;
            w_addr_d  = '0;
            w_wdata_d = '0;
            w_rdata_d = '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_acc && !w_mis) begin
                        w_addr_d  = {ALUResult_i[DATA_W-1:2], 2'b00};
                        w_wdata_d = RS2data_i;
                        // Read+write together is illegal; treat as a write.
                        w_we_d    = MemWrite_i;
                        w_cnt_d   = '0;
                        w_err_d   = 1'b0;
                        w_state_d = StAccess;
                    end else if (w_mis) begin
                        w_mis_err_d = 1'b1;
                    end
                end
                StAccess: begin
                    if (r_cnt != CNT_MAX) begin
                        w_cnt_d = r_cnt + 1'b1;
                    end
                    // Ack takes priority over a coincident timeout.
                    if (mem_ack_i) begin
                        if (!r_we) begin
                            w_rdata_d = mem_rdata_i;
                        end
                        w_state_d = StDone;
                    end else if (r_cnt == CNT_LAST) begin
                        w_err_d   = 1'b1;
                        w_state_d = StDone;
                    end
                end
                StDone: begin
                    // Never re-issue: the held instruction leaves this cycle.
                    w_state_d = StIdle;
                end
                default: begin
                    w_state_d = StIdle;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_mis_err <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
        end else begin
            r_state   <= w_state_d;
            r_cnt     <= w_cnt_d;
            r_err     <= w_err_d;
            r_mis_err <= w_mis_err_d;
            r_we      <= w_we_d;
            r_addr    <= w_addr_d;
            r_wdata   <= w_wdata_d;
            r_rdata   <= w_rdata_d;
        end
    end

    // Output decode from registered state plus pipeline pass-through.
    always_comb begin
        w_stall     = (w_in_idle & w_acc & ~w_mis) | w_in_access;
        stall_o     = w_stall;
        mem_req_o   = w_in_access;
        mem_we_o    = r_we;
        mem_addr_o  = r_addr;
        mem_wdata_o = r_wdata;
        ReadData_o  = r_rdata;
        error_o     = (w_in_done & r_err) | r_mis_err;
        RegWrite_o  = RegWrite_i & ~w_stall & ~w_mis & ~(w_in_done & r_err);
        ALUResult_o = ALUResult_i;
        MemtoReg_o  = MemtoReg_i;
        RDaddr_o    = RDaddr_i;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: table of directed transactions,
// hand-written disruption sequences and randomized transactions.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    localparam int unsigned T = 8;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [31:0] ALUResult_i, RS2data_i;
    logic        MemRead_i, MemWrite_i, MemtoReg_i, RegWrite_i;
    logic [4:0]  RDaddr_i;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        stall_o;
    logic [31:0] ALUResult_o, ReadData_o;
    logic        MemtoReg_o, RegWrite_o;
    logic [4:0]  RDaddr_o;
    logic        error_o;

    mem_access_unit #(.TIMEOUT_CYC(T)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .ALUResult_i (ALUResult_i),
        .RS2data_i   (RS2data_i),
        .MemRead_i   (MemRead_i),
        .MemWrite_i  (MemWrite_i),
        .MemtoReg_i  (MemtoReg_i),
        .RegWrite_i  (RegWrite_i),
        .RDaddr_i    (RDaddr_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .stall_o     (stall_o),
        .ALUResult_o (ALUResult_o),
        .ReadData_o  (ReadData_o),
        .MemtoReg_o  (MemtoReg_o),
        .RegWrite_o  (RegWrite_o),
        .RDaddr_o    (RDaddr_o),
        .error_o     (error_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rw;
        int          lat;        // ack on this ACCESS cycle; > T means never
        logic [31:0] rdata;
        int          exp_req;    // cycles with mem_req_o high
        int          exp_stall;  // cycles with stall_o high
        logic        exp_rw;     // RegWrite_o when the instruction leaves
        logic        exp_err;    // error_o when the instruction leaves
        logic        exp_err_nx; // error_o on the following cycle
        logic [31:0] exp_rdata;  // ReadData_o when the instruction leaves
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] model_rdata = 32'h0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic rw, input int lat,
                                input logic [31:0] rdata, input int ereq, input int estall,
                                input logic erw, input logic eerr, input logic eerr_nx,
                                input logic [31:0] erdata);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.rw = rw; v.lat = lat;
        v.rdata = rdata; v.exp_req = ereq; v.exp_stall = estall; v.exp_rw = erw;
        v.exp_err = eerr; v.exp_err_nx = eerr_nx; v.exp_rdata = erdata;
        return v;
    endfunction

    task automatic drive_bubble();
        start_i = 1'b1; MemRead_i = 1'b0; MemWrite_i = 1'b0; RegWrite_i = 1'b0;
        MemtoReg_i = 1'b0; ALUResult_i = 32'h0; RS2data_i = 32'h0; RDaddr_i = 5'd0;
        mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic run_vec(input vec_t v, input string tag);
        int   req_n, stall_n;
        logic bad_port, bad_rw, done;
        start_i = 1'b1; MemRead_i = v.rd; MemWrite_i = v.wr; ALUResult_i = v.addr;
        RS2data_i = v.wdata; RegWrite_i = v.rw; MemtoReg_i = v.rd; RDaddr_i = 5'd7;
        mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
        req_n = 0; stall_n = 0; bad_port = 1'b0; bad_rw = 1'b0; done = 1'b0;
        for (int cyc = 0; cyc < int'(T) + 6 && !done; cyc++) begin
            @(negedge clk_i);
            if (mem_req_o === 1'b1) begin
                req_n++;
                if (mem_addr_o !== {v.addr[31:2], 2'b00} || mem_wdata_o !== v.wdata ||
                    mem_we_o !== v.wr) bad_port = 1'b1;
                if (req_n == v.lat) begin
                    mem_ack_i = 1'b1;
                    mem_rdata_i = v.rdata;
                end
            end
            if (stall_o === 1'b1) begin
                stall_n++;
                if (RegWrite_o !== 1'b0) bad_rw = 1'b1;
            end else begin
                done = 1'b1;
                check32({tag, " regwrite"}, {31'd0, RegWrite_o}, {31'd0, v.exp_rw});
                check32({tag, " error"}, {31'd0, error_o}, {31'd0, v.exp_err});
                check32({tag, " readdata"}, ReadData_o, v.exp_rdata);
                check32({tag, " aluresult"}, ALUResult_o, v.addr);
            end
            @(posedge clk_i); #1;
            mem_ack_i = 1'b0;
            mem_rdata_i = 32'h0;
        end
        check32({tag, " completed"}, {31'd0, done}, 32'd1);
        check32({tag, " req cycles"}, req_n, v.exp_req);
        check32({tag, " stall cycles"}, stall_n, v.exp_stall);
        check32({tag, " port stable"}, {31'd0, bad_port}, 32'd0);
        check32({tag, " regwrite gated"}, {31'd0, bad_rw}, 32'd0);
        drive_bubble();
        @(negedge clk_i);
        check32({tag, " next error"}, {31'd0, error_o}, {31'd0, v.exp_err_nx});
        check32({tag, " next req"}, {31'd0, mem_req_o}, 32'd0);
        check32({tag, " next stall"}, {31'd0, stall_o}, 32'd0);
        @(posedge clk_i); #1;
    endtask

    vec_t tbl[9];
    vec_t v;
    int   op;
    logic acc, mis, acked;

    initial begin
        rst_i = 1'b0;
        drive_bubble();
        start_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check32("reset req", {31'd0, mem_req_o}, 32'd0);
        check32("reset we", {31'd0, mem_we_o}, 32'd0);
        check32("reset addr", mem_addr_o, 32'd0);
        check32("reset wdata", mem_wdata_o, 32'd0);
        check32("reset readdata", ReadData_o, 32'd0);
        check32("reset error", {31'd0, error_o}, 32'd0);
        rst_i = 1'b1;
        @(posedge clk_i); #1;

        //          rd wr addr          wdata         rw lat  rdata         req st rw er nx exp_rdata
        tbl[0] = mk(1, 0, 32'h100, 32'h0,       1, 3,  32'hDEADBEEF, 3, 4, 1, 0, 0, 32'hDEADBEEF);
        tbl[1] = mk(0, 1, 32'h104, 32'h12345678, 0, 1, 32'h0,        1, 2, 0, 0, 0, 32'hDEADBEEF);
        tbl[2] = mk(1, 0, 32'h102, 32'h0,       1, 1,  32'h0,        0, 0, 0, 0, 1, 32'hDEADBEEF);
        tbl[3] = mk(1, 0, 32'h200, 32'h0,       1, 99, 32'h0,        8, 9, 0, 1, 0, 32'hDEADBEEF);
        tbl[4] = mk(0, 0, 32'h55,  32'h0,       1, 1,  32'h0,        0, 0, 1, 0, 0, 32'hDEADBEEF);
        tbl[5] = mk(1, 1, 32'h300, 32'hA5A5A5A5, 1, 2, 32'hCAFEF00D, 2, 3, 1, 0, 0, 32'hDEADBEEF);
        tbl[6] = mk(1, 0, 32'h40,  32'h0,       1, 8,  32'h0BADC0DE, 8, 9, 1, 0, 0, 32'h0BADC0DE);
        tbl[7] = mk(0, 1, 32'h3,   32'h1,       0, 1,  32'h0,        0, 0, 0, 0, 1, 32'h0BADC0DE);
        tbl[8] = mk(1, 0, 32'h44,  32'h0,       1, 1,  32'h00C0FFEE, 1, 2, 1, 0, 0, 32'h00C0FFEE);
        for (int i = 0; i < 9; i++) run_vec(tbl[i], $sformatf("vec%0d", i));
        model_rdata = 32'h00C0FFEE;

        // Ack while idle must be ignored.
        drive_bubble();
        mem_ack_i = 1'b1;
        mem_rdata_i = 32'h11111111;
        @(negedge clk_i);
        check32("idle ack req", {31'd0, mem_req_o}, 32'd0);
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        check32("idle ack readdata", ReadData_o, model_rdata);
        check32("idle ack error", {31'd0, error_o}, 32'd0);
        @(posedge clk_i); #1;

        // start_i dropped on the 2nd ACCESS cycle: back to idle, no DONE pulse.
        start_i = 1'b1; MemRead_i = 1'b1; ALUResult_i = 32'h80; RegWrite_i = 1'b1;
        @(negedge clk_i);
        check32("flush first stall", {31'd0, stall_o}, 32'd1);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        start_i = 1'b0; MemRead_i = 1'b0; RegWrite_i = 1'b0;
        @(negedge clk_i);
        check32("flush req held", {31'd0, mem_req_o}, 32'd1);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check32("flush req drop", {31'd0, mem_req_o}, 32'd0);
        check32("flush stall", {31'd0, stall_o}, 32'd0);
        check32("flush error", {31'd0, error_o}, 32'd0);
        @(posedge clk_i); #1;
        drive_bubble();
        @(negedge clk_i);
        check32("flush no done error", {31'd0, error_o}, 32'd0);
        check32("flush no done req", {31'd0, mem_req_o}, 32'd0);
        @(posedge clk_i); #1;
        model_rdata = 32'h0;

        // Randomized transactions against a transaction-level model.
        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 3));
            v.rd = (op == 1 || op == 3);
            v.wr = (op == 2 || op == 3);
            v.addr = $urandom;
            if ($urandom_range(0, 3) != 0) v.addr[1:0] = 2'b00;
            v.wdata = $urandom;
            v.rw = 1'($urandom_range(0, 1));
            v.lat = int'($urandom_range(1, T + 2));
            v.rdata = $urandom;
            acc = v.rd | v.wr;
            mis = acc && (v.addr % 4 != 0);
            acked = (v.lat <= int'(T));
            if (acc && !mis) begin
                v.exp_req = acked ? v.lat : int'(T);
                v.exp_stall = v.exp_req + 1;
                if (acked && v.rd && !v.wr) model_rdata = v.rdata;
            end else begin
                v.exp_req = 0;
                v.exp_stall = 0;
            end
            v.exp_err = acc && !mis && !acked;
            v.exp_rw = v.rw && !mis && !v.exp_err;
            v.exp_err_nx = mis;
            v.exp_rdata = model_rdata;
            run_vec(v, $sformatf("rnd%0d", i));
        end

        // Asynchronous reset on the 2nd ACCESS cycle drops the request at once.
        start_i = 1'b1; MemRead_i = 1'b1; ALUResult_i = 32'h90; RegWrite_i = 1'b1;
        @(posedge clk_i); #1;
        @(posedge clk_i); #2;
        check32("rst before req", {31'd0, mem_req_o}, 32'd1);
        rst_i = 1'b0;
        #1;
        check32("rst req drop", {31'd0, mem_req_o}, 32'd0);
        check32("rst readdata", ReadData_o, 32'd0);
        drive_bubble();
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check32("rst idle req", {31'd0, mem_req_o}, 32'd0);
        check32("rst idle error", {31'd0, error_o}, 32'd0);
        check32("rst idle stall", {31'd0, stall_o}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
